rpg_uart_rx: RTL

UART receive front end for the reprogramming path. It sits between the RPG_RX pin (gpio[8]) and the reprogram loader, which turns bytes into rpg_addr/rpg_data/rpg_write.
- Synchronises and oversamples the serial line.
- Deframes 8N1 characters.
- Buffers received bytes in a small FIFO, so the loader can stall (e.g. while memory is busy) without losing data.
- Presents bytes on a valid/ready stream.

---
 rtl/rpg_uart_rx_pkg.sv | 13 +
 rtl/rpg_byte_fifo.sv | 58 +++++
 rtl/rpg_uart_rx.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/rpg_uart_rx_pkg.sv
// rpg_uart_rx shared types
// Receiver state encoding
package rpg_uart_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } uart_state_e;

endpackage

// File: rtl/rpg_byte_fifo.sv
// rpg_byte_fifo: first-word-fall-through byte queue
// Head is visible whenever non-empty; push while full is accepted only with a pop
module rpg_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] P_ONE = AW'(1);
  localparam logic [AW:0]   C_ONE = (AW+1)'(1);
  localparam logic [AW:0]   C_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == C_FULL);
  assign o_count = r_count;
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_data  = o_empty ? '0 : r_mem[r_rd];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + P_ONE;
      if (w_pop)  r_rd <= r_rd + P_ONE;
      if (w_push && !w_pop)
        r_count <= r_count + C_ONE;
      else if (w_pop && !w_push)
        r_count <= r_count - C_ONE;
    end
  end

  // Storage write; a full-with-pop push overwrites the slot being read out
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/rpg_uart_rx.sv
// rpg_uart_rx: 8N1 oversampling UART receiver with byte FIFO
// Feeds the reprogram loader through a valid/ready byte stream
module rpg_uart_rx
  import rpg_uart_rx_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx,
  output logic [7:0]                  byte_data,
  output logic                        byte_valid,
  input  logic                        byte_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        rx_busy,
  output logic                        frame_err,
  output logic                        overrun
);

  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_RLD   = TW'(DIV - 1);
  localparam logic [TW-1:0] T_ONE   = TW'(1);
  localparam logic [SW-1:0] SC_MID  = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] SC_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SC_ONE  = SW'(1);

  logic          r_meta;
  logic          r_rxs;
  uart_state_e   r_state;
  uart_state_e   w_state_nxt;
  logic [TW-1:0] r_tcnt;
  logic [SW-1:0] r_sc;
  logic [1:0]    r_samp;
  logic [7:0]    r_shift;
  logic [2:0]    r_bitcnt;
  logic          r_push;
  logic [7:0]    r_push_data;
  logic          r_ferr;
  logic          w_tick;
  logic          w_vote;
  logic          w_leave_idle;
  logic          w_push;
  logic          w_ferr;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;

  assign w_tick = (r_state != S_IDLE) && (r_tcnt == '0);
  assign w_vote = (r_samp[1] & r_samp[0]) |
                  (r_samp[1] & r_rxs) |
                  (r_samp[0] & r_rxs);

  // Two-flop synchroniser for the asynchronous line, idles high
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_rxs  <= 1'b1;
    end else begin
      r_meta <= rx;
      r_rxs  <= r_meta;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and strobe decode
  always_comb begin
    w_state_nxt  = r_state;
    w_leave_idle = 1'b0;
    w_push       = 1'b0;
    w_ferr       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!r_rxs) begin
          w_state_nxt  = S_START;
          w_leave_idle = 1'b1;
        end
      end
      S_START: begin
        if (w_tick && r_sc == SC_MID)
          w_state_nxt = w_vote ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_tick && r_sc == SC_LAST && r_bitcnt == 3'd7)
          w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_tick && r_sc == SC_LAST) begin
          if (w_vote) begin
            w_push      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (r_rxs) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Tick divider, sample counter, vote window and byte assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tcnt      <= T_RLD;
      r_sc        <= '0;
      r_samp      <= 2'b11;
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_push      <= 1'b0;
      r_push_data <= '0;
      r_ferr      <= 1'b0;
    end else begin
      r_push <= w_push;
      r_ferr <= w_ferr;
      if (w_push) r_push_data <= r_shift;
      if (w_leave_idle)
        r_tcnt <= T_RLD;
      else if (r_state != S_IDLE)
        r_tcnt <= (r_tcnt == '0) ? T_RLD : r_tcnt - T_ONE;
      if (w_leave_idle) begin
        r_sc     <= '0;
        r_bitcnt <= '0;
      end else if (w_tick) begin
        r_samp <= {r_samp[0], r_rxs};
        if ((r_state == S_START && r_sc == SC_MID) ||
            r_sc == SC_LAST)
          r_sc <= '0;
        else
          r_sc <= r_sc + SC_ONE;
        if (r_state == S_DATA && r_sc == SC_LAST) begin
          r_shift  <= {w_vote, r_shift[7:1]};
          r_bitcnt <= r_bitcnt + 3'd1;
        end
      end
    end
  end

  assign w_pop      = byte_valid & byte_ready;
  assign byte_valid = ~w_empty;
  assign rx_busy    = (r_state != S_IDLE);
  assign frame_err  = r_ferr;
  assign overrun    = r_push & w_full & ~w_pop;

  rpg_byte_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_push),
    .i_data  (r_push_data),
    .i_pop   (w_pop),
    .o_data  (byte_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

endmodule
